uart_loop_top: RTL and testbench
================================

Name: uart_loop_top

Overview:
UART loopback block: an 8N1 serial receiver deserializes bytes arriving on rx_serial and queues them to an 8N1 serial transmitter that re-sends each byte unchanged on tx_serial. It sits at board level as a link/echo self-test between a host UART and the FPGA. The bit rate is set by a clocks-per-bit parameter; 10 MHz clk with 87 clocks/bit gives ~115200 baud.

Parameters:
c_CLKS_PER_BIT, 87, clk cycles per serial bit; legal range 4..65535.
c_FIFO_DEPTH, 4, entries in the RX-to-TX byte queue (power of 2, >=2); used only when UART_LOOP_FIFO_EN is defined.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
rx_serial  input  1  serial data in; idle high; 8N1, LSB first.
tx_serial  output  1  serial data out; idle high; 8N1, LSB first.

Behaviour:
- Reset (async assert, sync deassert internally): tx_serial=1; RX FSM=IDLE; TX FSM=IDLE; queue empty; counters 0; rx synchronizer flops preset to 1.
- rx_serial passes a 2-flop synchronizer; all RX timing is relative to the synchronized signal (+2 cycles latency).
- RX FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE: a low on synced rx -> START, clear the clock counter.
  - START: at count = c_CLKS_PER_BIT/2 (integer divide) sample. Low -> DATA, counter cleared. High -> glitch, return to IDLE.
  - DATA: every c_CLKS_PER_BIT clocks, sample one bit into index 0..7 (LSB first). After bit 7 -> STOP.
  - STOP: after c_CLKS_PER_BIT clocks, sample. High -> byte valid. Low -> framing error, byte discarded. Either way -> DONE.
  - DONE: one cycle; a valid byte is pushed to the queue (1-cycle write strobe). Then -> IDLE.
  - Mid-bit sampling tolerates +/-40% bit-edge offset.
- Queue: a valid byte arriving when the queue is full is dropped; queued contents are preserved. Push and pop in the same cycle are both honored.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the queue is non-empty, pop one byte -> START on the next clock.
  - START: drive 0 for c_CLKS_PER_BIT clocks.
  - DATA: drive bits 0..7, each for c_CLKS_PER_BIT clocks.
  - STOP: drive 1 for c_CLKS_PER_BIT clocks, then -> IDLE.
  - Back-to-back bytes have no extra idle bit; the next START follows STOP immediately if data is queued.
- Latency: tx_serial falls no more than 3 clk after the DONE state of the received byte, when TX is idle.
- RX and TX operate independently (full duplex). Reception continues while TX is busy.
- Reset mid-frame aborts both FSMs immediately. tx_serial returns to 1 asynchronously. A partial byte is lost.

Optional Feature:
Macro UART_LOOP_FIFO_EN.
- Defined: the queue is a c_FIFO_DEPTH-entry circular FIFO with wrap-around read/write pointers and full/empty flags.
- Undefined: the queue is a single-byte holding register with a valid flag. A byte arriving while the register is still valid is dropped.
- All other behaviour is identical.

Test Plan:
- Reset -> tx_serial=1 and stays 1 with rx_serial idle high for 1000 clk.
- Send 0x3F at 87 clk/bit, start bit stretched +10 clk -> tx_serial emits start, 1,1,1,1,1,1,0,0, stop; byte decodes as 0x3F.
- Send 0x00 then 0xFF back-to-back -> echoed in order as 0x00, 0xFF with contiguous frames.
- rx_serial low pulse of 20 clk (shorter than half a bit) -> no byte echoed; tx_serial stays 1.
- Frame 0xA5 with stop bit forced low -> nothing echoed; the next valid 0x5A is echoed correctly.
- With UART_LOOP_FIFO_EN, send 6 bytes 0x01..0x06 back-to-back -> all echoed in order (TX drains while RX fills). Without it, assert rst during the 3rd byte echo -> tx_serial=1 immediately and no further output.

Source files
------------

// File: rtl/uart_loop_top.sv
// UART 8N1 loopback: serial receiver -> byte queue -> serial transmitter.
// Define UART_LOOP_FIFO_EN for a c_FIFO_DEPTH-entry FIFO queue; otherwise a single holding register is used.
module uart_loop_top #(
    parameter int unsigned c_CLKS_PER_BIT = 87,
    parameter int unsigned c_FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_serial,
    output logic tx_serial
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(c_CLKS_PER_BIT / 2);

    if (c_CLKS_PER_BIT < 4 || c_CLKS_PER_BIT > 65535 || c_FIFO_DEPTH < 2 ||
        (c_FIFO_DEPTH & (c_FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_loop_top: illegal c_CLKS_PER_BIT or c_FIFO_DEPTH");
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    // Reset: asserts asynchronously, releases two clocks after rst falls
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_i;
    assign rst_sync_d = {rst_sync_q[0], 1'b0};
    assign rst_i      = rst_sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= rst_sync_d;
    end

    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_serial;
            rx_sync_q <= rx_meta_q;
        end
    end

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_ok_q, rx_ok_d;
    logic             rx_push_c;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_byte_q  <= '0;
            rx_ok_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_byte_q  <= rx_byte_d;
            rx_ok_q    <= rx_ok_d;
        end
    end

    // RX: start bit qualified at mid-bit, data and stop sampled one bit period apart
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_byte_d  = rx_byte_q;
        rx_ok_d    = rx_ok_q;
        rx_push_c  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == BIT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d            = '0;
                    rx_byte_d[rx_idx_q] = rx_sync_q;
                    if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_idx_d   = rx_idx_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_ok_d    = rx_sync_q;
                    rx_state_d = RX_DONE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DONE: begin
                rx_push_c  = rx_ok_q;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    logic       q_empty_c;
    logic       q_pop_c;
    logic [7:0] q_data_c;

`ifdef UART_LOOP_FIFO_EN
    localparam int unsigned PTR_W = $clog2(c_FIFO_DEPTH);

    logic [7:0]       fifo_mem_q [c_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             q_full_c, wr_en_c;

    assign q_empty_c = (count_q == '0);
    assign q_full_c  = (count_q == (PTR_W + 1)'(c_FIFO_DEPTH));
    assign wr_en_c   = rx_push_c && !q_full_c;
    assign q_data_c  = fifo_mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = q_pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en_c && !q_pop_c)      count_d = count_q + (PTR_W + 1)'(1);
        else if (!wr_en_c && q_pop_c) count_d = count_q - (PTR_W + 1)'(1);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) fifo_mem_q[wr_ptr_q] <= rx_byte_q;
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic       hold_load_c;

    assign q_empty_c   = !hold_valid_q;
    assign q_data_c    = hold_q;
    assign hold_load_c = rx_push_c && (!hold_valid_q || q_pop_c);

    always_comb begin
        hold_d       = hold_load_c ? rx_byte_q : hold_q;
        hold_valid_d = hold_load_c ? 1'b1 : (q_pop_c ? 1'b0 : hold_valid_q);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_q, tx_d;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_byte_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_byte_q  <= tx_byte_d;
            tx_q       <= tx_d;
        end
    end

    // TX: line level is registered, chosen together with each state change
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_byte_d  = tx_byte_q;
        tx_d       = tx_q;
        q_pop_c    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!q_empty_c) begin
                    q_pop_c    = 1'b1;
                    tx_byte_d  = q_data_c;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = TX_DATA;
                    tx_d       = tx_byte_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        tx_d     = tx_byte_q[tx_idx_q + 3'd1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit when a byte is waiting
                    if (!q_empty_c) begin
                        q_pop_c    = 1'b1;
                        tx_byte_d  = q_data_c;
                        tx_state_d = TX_START;
                        tx_d       = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_d       = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign tx_serial = tx_q;

endmodule

// File: tb/tb_uart_loop_top.sv
// Scoreboard bench for uart_loop_top: every good frame sent must come back unchanged and in order.
module tb_uart_loop_top;

    localparam int unsigned CPB = 87;
    localparam longint      PERIOD = 100;

    logic clk = 1'b0;
    logic rst;
    logic rx_serial;
    logic tx_serial;

    always #50 clk = ~clk;

    uart_loop_top #(.c_CLKS_PER_BIT(CPB), .c_FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .rx_serial(rx_serial),
        .tx_serial(tx_serial)
    );

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_q[$];
    longint     start_t[$];
    int         frame_starts = 0;
    int         rst_gen = 0;
    bit         mon_busy = 1'b0;

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input int stretch, input logic stop_v);
        rx_serial = 1'b0;
        repeat (CPB + stretch) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop_v;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b, input int stretch);
        exp_q.push_back(b);
        send_frame(b, stretch, 1'b1);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 20000 && (exp_q.size() != 0 || mon_busy); t++) @(negedge clk);
        check_eq(name, longint'(exp_q.size()) + longint'(mon_busy), 0);
    endtask

    // Monitor: decode tx_serial as an ideal UART receiver and score each frame
    initial begin
        logic [7:0] got;
        logic       sb, pb;
        int         gen;
        forever begin
            @(negedge tx_serial);
            if (rst) continue;
            gen      = rst_gen;
            mon_busy = 1'b1;
            frame_starts++;
            start_t.push_back(longint'($time));
            repeat (CPB / 2) @(posedge clk);
            #1 sb = tx_serial;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 got[i] = tx_serial;
            end
            repeat (CPB) @(posedge clk);
            #1 pb = tx_serial;
            if (gen == rst_gen) begin
                check_eq("start_bit", sb, 0);
                check_eq("stop_bit", pb, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_byte: got 0x%02h expected no frame", got);
                end else begin
                    check_eq("echo_byte", got, exp_q.pop_front());
                end
            end
            mon_busy = 1'b0;
        end
    end

    initial begin
        int base;
        int idx;
        logic [7:0] rb;
        rx_serial = 1'b1;
        rst       = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("reset_tx", tx_serial, 1);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            repeat (100) @(negedge clk);
            check_eq("idle_tx", tx_serial, 1);
        end
        check_eq("idle_no_frames", frame_starts, 0);

        send_good(8'h3F, 10);
        drain("drain_3f");

        idx = start_t.size();
        send_good(8'h00, 0);
        send_good(8'hFF, 0);
        drain("drain_00_ff");
        if (start_t.size() >= idx + 2)
            check_eq("contiguous_frames", (start_t[idx+1] - start_t[idx]) / PERIOD, 10 * CPB);
        else
            check_eq("contiguous_frames_count", start_t.size() - idx, 2);

        base = frame_starts;
        rx_serial = 1'b0;
        repeat (20) @(negedge clk);
        rx_serial = 1'b1;
        repeat (2000) @(negedge clk);
        check_eq("glitch_no_echo", frame_starts - base, 0);
        check_eq("glitch_tx_idle", tx_serial, 1);

        base = frame_starts;
        send_frame(8'hA5, 0, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        send_good(8'h5A, 0);
        drain("drain_framing");
        check_eq("framing_one_echo", frame_starts - base, 1);

        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 5))
                0: begin
                    rx_serial = 1'b0;
                    repeat ($urandom_range(5, 35)) @(negedge clk);
                    rx_serial = 1'b1;
                    repeat (200) @(negedge clk);
                end
                1: begin
                    rb = 8'($urandom);
                    send_frame(rb, 0, 1'b0);
                    repeat (2 * CPB) @(negedge clk);
                end
                default: ;
            endcase
            rb = 8'($urandom);
            send_good(rb, int'($urandom_range(0, 10)));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 300)) @(negedge clk);
        end
        drain("drain_random");

`ifdef UART_LOOP_FIFO_EN
        base = frame_starts;
        for (int i = 1; i <= 6; i++) send_good(8'(i), 0);
        drain("drain_fifo6");
        check_eq("fifo6_frames", frame_starts - base, 6);
`else
        base = frame_starts;
        fork
            begin
                send_good(8'h11, 0);
                send_good(8'h22, 0);
                send_good(8'h33, 0);
            end
        join_none
        for (int t = 0; t < 5000 && frame_starts < base + 3; t++) @(negedge clk);
        check_eq("third_echo_started", frame_starts - base, 3);
        repeat (300) @(negedge clk);
        #3;
        rst_gen++;
        exp_q.delete();
        rst = 1'b1;
        #1;
        check_eq("tx_async_reset", tx_serial, 1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        base = frame_starts;
        repeat (2000) @(negedge clk);
        check_eq("post_reset_no_output", frame_starts - base, 0);
        check_eq("post_reset_tx", tx_serial, 1);
`endif

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
